// File: rtl/cache_request_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_request_scheduler_pkg
// Description : Shared types for the cache request scheduler: FSM state
//               encoding, captured-request record and owner-rotation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_request_scheduler_pkg;

    // The captured-request record is sized for the widest supported
    // configuration; the top slices out the active bits.
    localparam int c_max_addr_width = 64;
    localparam int c_max_id_width   = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DELIVER   = 2'd3
    } cache_request_scheduler_state;

    typedef struct packed {
        logic [c_max_addr_width-1:0] addr;
        logic [c_max_id_width-1:0]   id;
    } cache_request_scheduler_req_t;

    // Index following the owner, wrapping at the requester count.
    function automatic logic [c_max_id_width-1:0] crs_next_owner(
        input logic [c_max_id_width-1:0] owner,
        input int                        num
    );
        if (int'(owner) >= num - 1) begin
            return '0;
        end
        return owner + c_max_id_width'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_request_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_request_scheduler_if
// Description : Requester, cache and response handshake bundle of the cache
//               request scheduler. "master" is the scheduler's view, "slave"
//               the surrounding requesters and cache front end.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_request_scheduler_if
    import cache_request_scheduler_pkg::*;
#(
    parameter int NUM_REQUESTORS = 2,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 512,
    parameter int ID_WIDTH       = (NUM_REQUESTORS > 1) ? $clog2(NUM_REQUESTORS) : 1
);
    logic [NUM_REQUESTORS-1:0]            req_valid;
    logic [NUM_REQUESTORS-1:0]            req_ready;
    logic [NUM_REQUESTORS*ADDR_WIDTH-1:0] req_base_address;
    logic [NUM_REQUESTORS*ADDR_WIDTH-1:0] req_address_offset;
    logic                                 cache_req_valid;
    logic                                 cache_req_ready;
    logic [ADDR_WIDTH-1:0]                cache_req_addr;
    logic [ID_WIDTH-1:0]                  cache_req_id;
    logic                                 cache_resp_valid;
    logic [DATA_WIDTH-1:0]                cache_resp_rdata;
    logic [NUM_REQUESTORS-1:0]            resp_valid;
    logic [NUM_REQUESTORS-1:0]            resp_ready;
    logic [DATA_WIDTH-1:0]                resp_rdata;

    modport master (
        input  req_valid, req_base_address, req_address_offset,
        input  cache_req_ready, cache_resp_valid, cache_resp_rdata, resp_ready,
        output req_ready, cache_req_valid, cache_req_addr, cache_req_id,
        output resp_valid, resp_rdata
    );

    modport slave (
        output req_valid, req_base_address, req_address_offset,
        output cache_req_ready, cache_resp_valid, cache_resp_rdata, resp_ready,
        input  req_ready, cache_req_valid, cache_req_addr, cache_req_id,
        input  resp_valid, resp_rdata
    );

endinterface
`default_nettype wire

// File: rtl/cache_request_scheduler_rr_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_n
// Description : Combinational round-robin priority rotation. Grants the first
//               requesting index at or after rr_ptr, wrapping cyclically.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_n #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] rr_ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    logic [IDW-1:0] w_idx;
    logic           w_found;

    // Scan from rr_ptr cyclically and take the first active request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = IDW'((int'(rr_ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cache_request_scheduler
// Description : Shares one blocking cache request port among NUM_REQUESTORS
//               requesters with round-robin arbitration, one transaction in
//               flight, and routes the response back to its owner.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_request_scheduler
    import cache_request_scheduler_pkg::*;
#(
    parameter int NUM_REQUESTORS = 2,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 512,
    parameter int ID_WIDTH       = (NUM_REQUESTORS > 1) ? $clog2(NUM_REQUESTORS) : 1,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                       ap_clk,
    input  logic                       areset,
    cache_request_scheduler_if.master  bus,
    output logic                       busy,
    output logic [COUNT_WIDTH-1:0]     issued_count,
    output logic                       spurious_resp
);

    cache_request_scheduler_state r_state;
    cache_request_scheduler_state w_state_next;
    cache_request_scheduler_req_t r_cap;

    logic [ID_WIDTH-1:0]       r_rr_ptr;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic [COUNT_WIDTH-1:0]    r_issued_count;
    logic                      r_spurious;

    logic [NUM_REQUESTORS-1:0] w_grant;
    logic [ID_WIDTH-1:0]       w_grant_idx;
    logic [NUM_REQUESTORS-1:0] w_owner_onehot;
    logic [ADDR_WIDTH-1:0]     w_base;
    logic [ADDR_WIDTH-1:0]     w_offset;
    logic                      w_accept;
    logic                      w_issue_done;
    logic                      w_resp_take;
    logic                      w_deliver_done;

    rr_arbiter_n #(
        .N   (NUM_REQUESTORS),
        .IDW (ID_WIDTH)
    ) u_arb (
        .req       (bus.req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_base   = bus.req_base_address[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_offset = bus.req_address_offset[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];

    // Acceptance is suppressed during reset so no request is silently lost.
    assign w_accept       = (r_state == IDLE) && !areset && (|w_grant);
    assign w_owner_onehot = NUM_REQUESTORS'(1) << r_cap.id;
    assign w_issue_done   = (r_state == ISSUE) && bus.cache_req_ready;
    assign w_resp_take    = (r_state == WAIT_RESP) && bus.cache_resp_valid;
    assign w_deliver_done = (r_state == DELIVER) && (|(bus.resp_ready & w_owner_onehot));

    assign bus.req_ready       = w_accept ? w_grant : '0;
    assign bus.cache_req_valid = (r_state == ISSUE);
    assign bus.cache_req_addr  = r_cap.addr[ADDR_WIDTH-1:0];
    assign bus.cache_req_id    = r_cap.id[ID_WIDTH-1:0];
    assign bus.resp_valid      = (r_state == DELIVER) ? w_owner_onehot : '0;
    assign bus.resp_rdata      = r_rdata;

    assign busy          = (r_state != IDLE);
    assign issued_count  = r_issued_count;
    assign spurious_resp = r_spurious;

    // State register.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one transaction walks IDLE->ISSUE->WAIT_RESP->DELIVER.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_accept)       w_state_next = ISSUE;
            ISSUE:     if (w_issue_done)   w_state_next = WAIT_RESP;
            WAIT_RESP: if (w_resp_take)    w_state_next = DELIVER;
            DELIVER:   if (w_deliver_done) w_state_next = IDLE;
            default:                       w_state_next = IDLE;
        endcase
    end

    // Captured request, response data, counter, rotation pointer and flag.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_cap          <= '0;
            r_rdata        <= '0;
            r_issued_count <= '0;
            r_rr_ptr       <= '0;
            r_spurious     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cap.addr <= c_max_addr_width'(w_base + w_offset);
                r_cap.id   <= c_max_id_width'(w_grant_idx);
            end
            if (w_issue_done) begin
                r_issued_count <= r_issued_count + COUNT_WIDTH'(1);
            end
            if (w_resp_take) begin
                r_rdata <= bus.cache_resp_rdata;
            end
            if (w_deliver_done) begin
                r_rr_ptr <= ID_WIDTH'(crs_next_owner(r_cap.id, NUM_REQUESTORS));
            end
            // A response outside WAIT_RESP has no owner; drop it and remember.
            if (bus.cache_resp_valid && (r_state != WAIT_RESP)) begin
                r_spurious <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_request_scheduler
// Description : Self-checking bench: vector table, hand-written corner
//               sequences and randomized transactions against a reference
//               model of the arbitration and routing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_request_scheduler;

    localparam int N   = 2;
    localparam int AW  = 64;
    localparam int DW  = 512;
    localparam int IDW = 1;
    localparam int CW  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic [CW-1:0] issued_count;
    logic          spurious_resp;

    always #5 clk = ~clk;

    cache_request_scheduler_if #(
        .NUM_REQUESTORS (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .ID_WIDTH (IDW)
    ) bus ();

    cache_request_scheduler #(
        .NUM_REQUESTORS (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW),
        .ID_WIDTH (IDW), .COUNT_WIDTH (CW)
    ) dut (
        .ap_clk        (clk),
        .areset        (rst),
        .bus           (bus),
        .busy          (busy),
        .issued_count  (issued_count),
        .spurious_resp (spurious_resp)
    );

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   model_ptr  = 0;
    int   model_cnt  = 0;
    logic model_spur = 1'b0;

    typedef struct {
        logic [1:0]    mask;
        logic [63:0]   b0, o0, b1, o1;
        int            cd, rd, yd;
        logic [511:0]  data;
        int            exp_w;
        logic [63:0]   exp_addr;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    // Rule: first requester at or after the pointer, cyclically.
    function automatic int model_winner(input logic [1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic vec_t mk(input logic [1:0] mask, input logic [63:0] b0, o0, b1, o1,
                                input int cd, rd, yd, input logic [511:0] data,
                                input int w, input logic [63:0] addr);
        vec_t v;
        v.mask = mask; v.b0 = b0; v.o0 = o0; v.b1 = b1; v.o1 = o1;
        v.cd = cd; v.rd = rd; v.yd = yd; v.data = data; v.exp_w = w; v.exp_addr = addr;
        return v;
    endfunction

    // One complete transaction; starts and ends just after a falling edge.
    task automatic run_txn(input vec_t v);
        logic [N-1:0] oh;
        oh = N'(1) << v.exp_w;
        bus.req_valid          = v.mask;
        bus.req_base_address   = {v.b1, v.b0};
        bus.req_address_offset = {v.o1, v.o0};
        #1;
        chk("req_ready_grant", {510'd0, bus.req_ready}, {510'd0, oh});
        chk("busy_idle", {511'd0, busy}, 512'd0);
        @(negedge clk);
        for (int c = 0; c < v.cd; c++) begin
            bus.cache_req_ready = 1'b0;
            #1;
            chk("cache_req_valid_hold", {511'd0, bus.cache_req_valid}, 512'd1);
            chk("cache_req_addr_stable", {448'd0, bus.cache_req_addr}, {448'd0, v.exp_addr});
            chk("req_ready_while_busy", {510'd0, bus.req_ready}, 512'd0);
            @(negedge clk);
        end
        bus.cache_req_ready = 1'b1;
        #1;
        chk("cache_req_valid", {511'd0, bus.cache_req_valid}, 512'd1);
        chk("cache_req_addr", {448'd0, bus.cache_req_addr}, {448'd0, v.exp_addr});
        chk("cache_req_id", {511'd0, bus.cache_req_id}, 512'(v.exp_w));
        model_cnt++;
        @(negedge clk);
        bus.cache_req_ready = 1'b0;
        for (int c = 0; c < v.rd; c++) begin
            #1;
            chk("cache_req_valid_wait", {511'd0, bus.cache_req_valid}, 512'd0);
            chk("resp_valid_wait", {510'd0, bus.resp_valid}, 512'd0);
            chk("issued_count", {480'd0, issued_count}, 512'(model_cnt));
            @(negedge clk);
        end
        bus.cache_resp_valid = 1'b1;
        bus.cache_resp_rdata = v.data;
        @(negedge clk);
        bus.cache_resp_valid = 1'b0;
        bus.cache_resp_rdata = '0;
        for (int c = 0; c < v.yd; c++) begin
            bus.resp_ready = ~oh;
            #1;
            chk("resp_valid_hold", {510'd0, bus.resp_valid}, {510'd0, oh});
            chk("req_ready_while_busy", {510'd0, bus.req_ready}, 512'd0);
            @(negedge clk);
        end
        bus.resp_ready = oh;
        #1;
        chk("resp_valid", {510'd0, bus.resp_valid}, {510'd0, oh});
        chk("resp_rdata", bus.resp_rdata, v.data);
        chk("issued_count", {480'd0, issued_count}, 512'(model_cnt));
        @(negedge clk);
        bus.resp_ready = '0;
        bus.req_valid  = '0;
        #1;
        chk("resp_valid_drop", {510'd0, bus.resp_valid}, 512'd0);
        chk("busy_after", {511'd0, busy}, 512'd0);
        chk("spurious_resp", {511'd0, spurious_resp}, {511'd0, model_spur});
        model_ptr = (v.exp_w + 1) % N;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {511'd0, busy}, 512'd0);
        chk({tag, "_cache_req_valid"}, {511'd0, bus.cache_req_valid}, 512'd0);
        chk({tag, "_cache_req_addr"}, {448'd0, bus.cache_req_addr}, 512'd0);
        chk({tag, "_cache_req_id"}, {511'd0, bus.cache_req_id}, 512'd0);
        chk({tag, "_resp_valid"}, {510'd0, bus.resp_valid}, 512'd0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata, 512'd0);
        chk({tag, "_issued_count"}, {480'd0, issued_count}, 512'd0);
        chk({tag, "_spurious"}, {511'd0, spurious_resp}, 512'd0);
        chk({tag, "_req_ready"}, {510'd0, bus.req_ready}, 512'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic [1:0]  m;
        logic [63:0] b0, o0, b1, o1;
        int          w;

        rst = 1'b1;
        bus.req_valid = '0; bus.req_base_address = '0; bus.req_address_offset = '0;
        bus.cache_req_ready = 1'b0; bus.cache_resp_valid = 1'b0;
        bus.cache_resp_rdata = '0; bus.resp_ready = '0;

        tbl[0] = mk(2'b01, 64'h1000, 64'h40, 64'h0, 64'h0, 0, 0, 0, {64{8'hA5}}, 0, 64'h1040);
        tbl[1] = mk(2'b10, 64'h0, 64'h0, 64'h2000, 64'h8, 1, 0, 0, {64{8'h5A}}, 1, 64'h2008);
        tbl[2] = mk(2'b11, 64'h3000, 64'h100, 64'h4000, 64'h200, 0, 1, 0, {64{8'h11}}, 0, 64'h3100);
        tbl[3] = mk(2'b11, 64'h3010, 64'h10, 64'h4010, 64'h20, 0, 0, 1, {64{8'h22}}, 1, 64'h4030);
        tbl[4] = mk(2'b11, 64'h6000, 64'h1, 64'h7000, 64'h2, 2, 0, 0, {64{8'h33}}, 0, 64'h6001);
        tbl[5] = mk(2'b11, 64'h8000, 64'h8, 64'h9000, 64'h9, 0, 2, 0, {64{8'h44}}, 1, 64'h9009);
        tbl[6] = mk(2'b01, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0, 64'h0, 0, 0, 0, {64{8'h55}}, 0, 64'h10);
        tbl[7] = mk(2'b11, 64'h5000, 64'h1, 64'h5000, 64'h10, 5, 2, 3, {64{8'h66}}, 1, 64'h5010);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("reset");

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i]);
        end

        // Response pulse while idle: dropped, flag set and sticky.
        bus.cache_resp_valid = 1'b1;
        bus.cache_resp_rdata = {16{32'hDEAD_BEEF}};
        @(negedge clk);
        bus.cache_resp_valid = 1'b0;
        #1;
        chk("spurious_set", {511'd0, spurious_resp}, 512'd1);
        chk("spurious_no_resp", {510'd0, bus.resp_valid}, 512'd0);
        chk("spurious_idle", {511'd0, busy}, 512'd0);
        model_spur = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("spurious_sticky", {511'd0, spurious_resp}, 512'd1);

        // Move the pointer to 1, then reset in WAIT_RESP.
        run_txn(mk(2'b01, 64'hA000, 64'h4, 64'h0, 64'h0, 0, 0, 0, {64{8'h77}}, 0, 64'hA004));
        bus.req_valid          = 2'b11;
        bus.req_base_address   = {64'hB000, 64'hC000};
        bus.req_address_offset = {64'h1, 64'h2};
        #1;
        chk("midop_grant", {510'd0, bus.req_ready}, 512'd2);
        @(negedge clk);
        bus.req_valid = '0;
        bus.cache_req_ready = 1'b1;
        @(negedge clk);
        bus.cache_req_ready = 1'b0;
        #1;
        chk("midop_busy", {511'd0, busy}, 512'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("midop_reset");
        model_ptr = 0; model_cnt = 0; model_spur = 1'b0;
        bus.cache_resp_valid = 1'b1;
        @(negedge clk);
        bus.cache_resp_valid = 1'b0;
        #1;
        chk("late_resp_spurious", {511'd0, spurious_resp}, 512'd1);
        chk("late_resp_no_valid", {510'd0, bus.resp_valid}, 512'd0);
        chk("late_resp_idle", {511'd0, busy}, 512'd0);
        model_spur = 1'b1;
        run_txn(mk(2'b11, 64'hD000, 64'h3, 64'hE000, 64'h5, 0, 0, 0, {64{8'h88}}, 0, 64'hD003));

        // Randomized traffic checked against the model.
        for (int t = 0; t < 40; t++) begin
            m  = 2'(1 + $urandom_range(0, 2));
            b0 = {$urandom, $urandom}; o0 = {$urandom, $urandom};
            b1 = {$urandom, $urandom}; o1 = {$urandom, $urandom};
            w  = model_winner(m, model_ptr);
            v  = mk(m, b0, o0, b1, o1, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3),
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    w, (w == 0) ? b0 + o0 : b1 + o1);
            run_txn(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_request_scheduler.md
Name: cache_request_scheduler

Overview:
- Shares one blocking cache request port between NUM_REQUESTORS memory requesters using round-robin arbitration.
- Keeps exactly one transaction in flight. The sequence is: accept a request, issue it to the cache, wait for the cache response, then route the read data back to the owning requester.
- Sits between the engine-side memory requesters and the cache request FIFO and cache front end.
- Replaces free-running valid-only arbitration with full valid/ready handshakes and response routing.

Parameters:
- NUM_REQUESTORS, 2, number of requester ports (1..16).
- ADDR_WIDTH, 64, cache byte address width.
- DATA_WIDTH, 512, cache line data width.
- ID_WIDTH, (NUM_REQUESTORS>1 ? $clog2(NUM_REQUESTORS) : 1), owner tag width.
- COUNT_WIDTH, 32, width of the issued-transaction counter.

Ports:
- ap_clk  in  1  clock; all logic is on the rising edge.
- areset  in  1  reset, synchronous and active-high.
- req_valid  in  NUM_REQUESTORS  per-requester request valid.
- req_ready  out  NUM_REQUESTORS  per-requester accept strobe.
- req_base_address  in  NUM_REQUESTORS*ADDR_WIDTH  packed base addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_address_offset  in  NUM_REQUESTORS*ADDR_WIDTH  packed offsets, same packing.
- cache_req_valid  out  1  request to cache.
- cache_req_ready  in  1  cache accepts request.
- cache_req_addr  out  ADDR_WIDTH  base+offset of the captured request.
- cache_req_id  out  ID_WIDTH  owner index.
- cache_resp_valid  in  1  cache response strobe.
- cache_resp_rdata  in  DATA_WIDTH  response line.
- resp_valid  out  NUM_REQUESTORS  one-hot response valid to the owner.
- resp_ready  in  NUM_REQUESTORS  requester accepts response.
- resp_rdata  out  DATA_WIDTH  response data, broadcast to all requesters.
- busy  out  1  high in every state except IDLE.
- issued_count  out  COUNT_WIDTH  completed cache handshakes.
- spurious_resp  out  1  sticky flag: cache_resp_valid was seen outside WAIT_RESP.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, and every output 0. Captured addr/id/rdata are also cleared to 0.
- The FSM has four states: IDLE, ISSUE, WAIT_RESP, DELIVER.
- IDLE:
  - Winner is the lowest index i with req_valid[i], searching cyclically from rr_ptr.
  - req_ready[winner]=1 combinationally, only while in IDLE and only when some req_valid is high. All other req_ready bits are 0.
  - Handshake (req_valid & req_ready): capture addr = base+offset (modulo 2^ADDR_WIDTH, carry discarded) and owner=winner, then go to ISSUE.
- ISSUE:
  - cache_req_valid=1 (registered; first asserted the cycle after acceptance), with addr and id stable.
  - Held until cache_req_ready. On that handshake: issued_count+1 (wraps to 0 at max), go to WAIT_RESP.
- WAIT_RESP:
  - On cache_resp_valid, capture rdata and go to DELIVER.
  - A response arriving in the same cycle as the ISSUE handshake is ignored (cache contract: response ≥1 cycle after accept).
- DELIVER:
  - resp_valid[owner]=1 and resp_rdata valid, held until resp_ready[owner].
  - Then rr_ptr = (owner+1) mod NUM_REQUESTORS and go to IDLE. resp_valid drops the next cycle.
- Best-case latency: accept at cycle 0 → cache_req_valid at cycle 1 → with immediate cache ready and response at cycle 2 → resp_valid at cycle 3. Next acceptance is possible in the cycle after the resp handshake.
- cache_resp_valid in IDLE, ISSUE or DELIVER is dropped and sets spurious_resp. The flag clears only on reset.
- A requester holding req_valid is granted within NUM_REQUESTORS transactions (fairness).
- rr_ptr advances only on completed delivery, never on acceptance.
- Reset mid-operation:
  - Returns to IDLE immediately and abandons the transaction in flight; no resp_valid is produced for it.
  - A late response from the abandoned transaction sets spurious_resp.
- NUM_REQUESTORS=1: the arbiter degenerates to a pass-through and cache_req_id=0.

Decomposition:
- Shared memory package gets:
  - typedef cache_request_scheduler_state enum {IDLE, ISSUE, WAIT_RESP, DELIVER};
  - a struct pairing address/id for the captured request.
- One sub-module: rr_arbiter_n (req vector, rr_ptr in → one-hot grant plus index out; purely combinational priority rotation).
- Counter and FSM live in the top module.

Test Plan:
- Single request: req_valid[0]=1 with base 0x1000 and offset 0x40. Required: cache_req_addr=0x1040 and id=0 at cycle 1; with cache_resp rdata=0xA5.. returned, resp_valid=2'b01 with that data; issued_count=1.
- Round-robin: both req_valid held high for 4 transactions. Required: grant order 0,1,0,1; each requester receives only its own resp_valid.
- Backpressure: cache_req_ready low for 5 cycles, then resp_ready[1] low for 3 cycles. Required: cache_req_valid held 5 cycles with addr stable; resp_valid[1] held 3 cycles; no new req_ready until delivery completes.
- Spurious response: cache_resp_valid pulsed in IDLE. Required: spurious_resp=1 and stays 1; state stays IDLE; no resp_valid.
- Reset mid-op: areset asserted in WAIT_RESP. Required: next cycle all outputs 0 and busy=0; a later cache_resp_valid sets spurious_resp only; the next request is issued normally starting from rr_ptr=0.
- Address wrap: base 0xFFFF_FFFF_FFFF_FFF0 with offset 0x20. Required: cache_req_addr=0x10.
